// File: rtl/top.sv
// rtl/top.sv - TMR voter with Hamming(7,4) encode, bitwise vote, syndrome correction
module voter (
  input  logic [6:0] cw1_i,
  input  logic [6:0] cw2_i,
  input  logic [6:0] cw3_i,
  output logic [6:0] voted_o
);

  // Kept as a named net so benches can inject arbitrary voted codewords here.
  logic [6:0] data_voted;

  assign data_voted = (cw1_i & cw2_i) | (cw1_i & cw3_i) | (cw2_i & cw3_i);
  assign voted_o    = data_voted;

endmodule

module top (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_1,
  input  logic [3:0] data_2,
  input  logic [3:0] data_3,
  output logic [3:0] voted_q,
  output logic       fault
);

  // Codeword layout {p1,p2,d1,p3,d2,d3,d4}; bit 6 is Hamming position 1.
  function automatic logic [6:0] hamming_encode(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[3] ^ d[2] ^ d[0];
    p2 = d[3] ^ d[1] ^ d[0];
    p3 = d[2] ^ d[1] ^ d[0];
    return {p1, p2, d[3], p3, d[2], d[1], d[0]};
  endfunction

  logic [6:0] cw1, cw2, cw3;
  logic [6:0] cw_voted;
  logic [2:0] syn;
  logic [3:0] voted_d;
  logic       fault_d;
  logic       fault_q;

  assign cw1 = hamming_encode(data_1);
  assign cw2 = hamming_encode(data_2);
  assign cw3 = hamming_encode(data_3);

  voter voter_inst (
    .cw1_i   (cw1),
    .cw2_i   (cw2),
    .cw3_i   (cw3),
    .voted_o (cw_voted)
  );

  // Syndrome decode; only data positions 3,5,6,7 need correcting since parity is dropped.
  always_comb begin
    syn     = 3'd0;
    voted_d = 4'd0;
    fault_d = 1'b0;
    syn[0]  = cw_voted[6] ^ cw_voted[4] ^ cw_voted[2] ^ cw_voted[0];
    syn[1]  = cw_voted[5] ^ cw_voted[4] ^ cw_voted[1] ^ cw_voted[0];
    syn[2]  = cw_voted[3] ^ cw_voted[2] ^ cw_voted[1] ^ cw_voted[0];
    voted_d = {cw_voted[4] ^ (syn == 3'd3),
               cw_voted[2] ^ (syn == 3'd5),
               cw_voted[1] ^ (syn == 3'd6),
               cw_voted[0] ^ (syn == 3'd7)};
    fault_d = (syn != 3'd0);
  end

  // Output register: captures the corrected nibble and fault flag every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voted_q <= 4'd0;
      fault_q <= 1'b0;
    end else begin
      voted_q <= voted_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - randomized self-checking bench for the TMR Hamming voter
module tb_top;

  logic       clk;
  logic       rst_n;
  logic [3:0] data_1, data_2, data_3;
  logic [3:0] voted_q;
  logic       fault;

  int checks = 0;
  int errors = 0;

  top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_1  (data_1),
    .data_2  (data_2),
    .data_3  (data_3),
    .voted_q (voted_q),
    .fault   (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: Hamming positions 1..7, position p stored at bit 7-p.
  function automatic logic [6:0] ref_encode(input logic [3:0] d);
    logic [6:0] cw;
    int dpos[4];
    dpos = '{3, 5, 6, 7};
    cw = '0;
    for (int k = 0; k < 4; k++) cw[7 - dpos[k]] = d[3 - k];
    // each parity position 2^j covers the positions whose index has bit j set
    for (int j = 0; j < 3; j++) begin
      int pp = 1 << j;
      logic par = 1'b0;
      for (int p = 1; p <= 7; p++)
        if (p != pp && ((p >> j) & 1)) par ^= cw[7 - p];
      cw[7 - pp] = par;
    end
    return cw;
  endfunction

  function automatic logic [6:0] ref_vote(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
    logic [6:0] v;
    for (int i = 0; i < 7; i++) v[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
    return v;
  endfunction

  // returns {fault, nibble}
  function automatic logic [4:0] ref_decode(input logic [6:0] cw);
    int syn = 0;
    logic [6:0] c = cw;
    for (int p = 1; p <= 7; p++) if (c[7 - p]) syn ^= p;
    if (syn != 0) c[7 - syn] = ~c[7 - syn];
    return {syn != 0, c[4], c[2], c[1], c[0]};
  endfunction

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    @(negedge clk);
    data_1 = a; data_2 = b; data_3 = c;
  endtask

  task automatic step_check(input string tag, input logic [4:0] exp);
    @(posedge clk); #1;
    check({tag, "_q"}, voted_q, exp[3:0]);
    check({tag, "_f"}, fault, exp[4]);
  endtask

  logic [4:0] exp;
  logic [6:0] fcw;

  initial begin
    rst_n = 1'b0;
    data_1 = 4'hF; data_2 = 4'h3; data_3 = 4'h9;
    #1;
    check("rst_q", voted_q, 4'd0);
    check("rst_f", fault, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(4'b1010, 4'b1010, 4'b1010);
    #1 check("dv_1010", dut.voter_inst.data_voted, 7'b1011010);
    step_check("t2", 5'b0_1010);

    drive(4'b1001, 4'b1010, 4'b1001);
    step_check("t3", 5'b0_1001);

    drive(4'b1100, 4'b1100, 4'b1000);
    force dut.voter_inst.data_voted = 7'b0111101;
    step_check("t4", 5'b1_1100);
    @(negedge clk);
    release dut.voter_inst.data_voted;
    step_check("t4rel", 5'b0_1100);

    drive(4'b0001, 4'b0010, 4'b0001);
    force dut.voter_inst.data_voted = 7'b1001001;
    step_check("t5a", 5'b1_0001);
    @(negedge clk);
    release dut.voter_inst.data_voted;
    drive(4'b1001, 4'b0010, 4'b1001);
    force dut.voter_inst.data_voted = 7'b0010001;
    step_check("t5b", 5'b1_1001);
    @(negedge clk);
    release dut.voter_inst.data_voted;

    drive(4'b1111, 4'b1111, 4'b1010);
    step_check("t6", 5'b0_1111);
    #2 rst_n = 1'b0;
    #1;
    check("t6rst_q", voted_q, 4'd0);
    check("t6rst_f", fault, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized copies, including fully disagreeing triples
    for (int n = 0; n < 300; n++) begin
      logic [3:0] a, b, c;
      a = 4'($urandom);
      b = ($urandom_range(0, 2) == 0) ? 4'($urandom) : a;
      c = ($urandom_range(0, 2) == 0) ? 4'($urandom) : a;
      drive(a, b, c);
      exp = ref_decode(ref_vote(ref_encode(a), ref_encode(b), ref_encode(c)));
      step_check("rnd", exp);
    end

    // injected voted codewords covering every syndrome value
    for (int n = 0; n < 64; n++) begin
      fcw = 7'($urandom);
      drive(4'($urandom), 4'($urandom), 4'($urandom));
      force dut.voter_inst.data_voted = fcw;
      step_check("inj", ref_decode(fcw));
      @(negedge clk);
      release dut.voter_inst.data_voted;
    end

    // single-bit upsets of valid codewords must be corrected with fault set
    for (int n = 0; n < 28; n++) begin
      logic [3:0] d;
      d = 4'($urandom);
      fcw = ref_encode(d) ^ (7'b1 << (n % 7));
      drive(d, d, d);
      force dut.voter_inst.data_voted = fcw;
      step_check("seu", {1'b1, d});
      @(negedge clk);
      release dut.voter_inst.data_voted;
    end

    // asynchronous reset in the middle of a random stream
    for (int n = 0; n < 8; n++) begin
      drive(4'($urandom), 4'($urandom), 4'($urandom));
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_q", voted_q, 4'd0);
      check("arst_f", fault, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
